// File: rtl/sync_reg_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sync_reg_arbiter
// Description : Round-robin arbiter guarding one shared synchronous register.
//               N requesters compete for ownership. The current owner writes
//               its data slice into 'result' on every edge that it keeps its
//               request high. Ownership is released when the owner drops its
//               request, or after MAX_HOLD captures. On release the next owner
//               is chosen in the same edge, so back-to-back grants have no idle
//               bubble.
// Ports       : clk          - single clock, rising-edge active
//               reset        - synchronous active-high reset
//               req[N]       - request per requester
//               data[N*W]    - write data, slice [i*W +: W] is requester i
//               gnt[N]       - registered one-hot owner (zero when idle)
//               gnt_id       - registered owner index (zero when idle)
//               result[W]    - shared register contents
//               result_valid - high for the single cycle after each capture
// Revision    : 1.0 - initial release
// ============================================================================
module sync_reg_arbiter #(
    parameter int N        = 4,
    parameter int W        = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N-1:0]         req,
    input  logic [N*W-1:0]       data,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] gnt_id,
    output logic [W-1:0]         result,
    output logic                 result_valid
);

    localparam int c_IW = $clog2(N);
    // hold_cnt only has to reach MAX_HOLD-1; keep at least one bit.
    localparam int c_HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

    localparam logic [0:0] c_IDLE  = 1'b0;
    localparam logic [0:0] c_OWNED = 1'b1;

    localparam logic [c_IW-1:0] c_LAST_ID  = c_IW'(N - 1);
    localparam logic [c_HW-1:0] c_LAST_HLD = c_HW'(MAX_HOLD - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [0:0]      state_q,    state_d;
    logic [c_IW-1:0] ptr_q,      ptr_d;
    logic [c_HW-1:0] hold_cnt_q, hold_cnt_d;
    logic [N-1:0]    gnt_q,      gnt_d;
    logic [c_IW-1:0] gnt_id_q,   gnt_id_d;
    logic [W-1:0]    result_q,   result_d;
    logic            result_valid_q, result_valid_d;

    // ------------------------------------------------------------------
    // Round-robin search: first set bit of r starting at 'start',
    // wrapping mod N. Returns {hit, index}.
    // ------------------------------------------------------------------
    function automatic logic [c_IW:0] f_search(
        input logic [c_IW-1:0] start,
        input logic [N-1:0]    r
    );
        logic            hit;
        logic [c_IW-1:0] idx;
        logic [c_IW-1:0] pos;
        hit = 1'b0;
        idx = '0;
        pos = start;
        for (int i = 0; i < N; i++) begin
            if (!hit && r[pos]) begin
                hit = 1'b1;
                idx = pos;
            end
            pos = (pos == c_LAST_ID) ? '0 : pos + c_IW'(1);
        end
        return {hit, idx};
    endfunction

    // ------------------------------------------------------------------
    // Shared combinational terms
    // ------------------------------------------------------------------
    logic            w_owner_req;
    logic            w_capture;
    logic [c_IW-1:0] w_next_k;
    logic [W-1:0]    w_owner_data;

    assign w_owner_req = req[gnt_id_q];
    assign w_capture   = (state_q == c_OWNED) && w_owner_req;
    // Where the search resumes after the current owner lets go.
    assign w_next_k    = (gnt_id_q == c_LAST_ID) ? '0 : gnt_id_q + c_IW'(1);

    // Owner data mux built from constant slices.
    always_comb begin
        w_owner_data = '0;
        for (int i = 0; i < N; i++) begin
            if (gnt_id_q == c_IW'(i)) begin
                w_owner_data = data[i*W +: W];
            end
        end
    end

    // ------------------------------------------------------------------
    // Process 1: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= c_IDLE;
            ptr_q          <= '0;
            hold_cnt_q     <= '0;
            gnt_q          <= '0;
            gnt_id_q       <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            ptr_q          <= ptr_d;
            hold_cnt_q     <= hold_cnt_d;
            gnt_q          <= gnt_d;
            gnt_id_q       <= gnt_id_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
        end
    end

    // ------------------------------------------------------------------
    // Process 2: next-state / ownership logic
    // ------------------------------------------------------------------
    logic [c_IW:0] w_idle_srch;
    logic [c_IW:0] w_rel_srch;
    logic          w_release;

    assign w_idle_srch = f_search(ptr_q, req);
    assign w_rel_srch  = f_search(w_next_k, req);

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        hold_cnt_d = hold_cnt_q;
        gnt_d      = gnt_q;
        gnt_id_d   = gnt_id_q;
        w_release  = 1'b0;

        case (state_q)
            c_IDLE: begin
                // Grant edge only; the first capture happens one edge later.
                if (w_idle_srch[c_IW]) begin
                    state_d    = c_OWNED;
                    gnt_d      = '0;
                    gnt_d[w_idle_srch[c_IW-1:0]] = 1'b1;
                    gnt_id_d   = w_idle_srch[c_IW-1:0];
                    hold_cnt_d = '0;
                end
            end
            c_OWNED: begin
                if (w_owner_req) begin
                    // The last permitted capture still happens, then we let go.
                    if (hold_cnt_q == c_LAST_HLD) begin
                        w_release = 1'b1;
                    end else begin
                        hold_cnt_d = hold_cnt_q + c_HW'(1);
                    end
                end else begin
                    w_release = 1'b1;
                end

                if (w_release) begin
                    ptr_d      = w_next_k;
                    hold_cnt_d = '0;
                    // Search starts past the old owner, so it is re-granted
                    // only when nobody else is asking.
                    if (w_rel_srch[c_IW]) begin
                        gnt_d    = '0;
                        gnt_d[w_rel_srch[c_IW-1:0]] = 1'b1;
                        gnt_id_d = w_rel_srch[c_IW-1:0];
                    end else begin
                        state_d  = c_IDLE;
                        gnt_d    = '0;
                        gnt_id_d = '0;
                    end
                end
            end
            default: begin
                state_d  = c_IDLE;
                gnt_d    = '0;
                gnt_id_d = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Process 3: output / datapath logic
    // ------------------------------------------------------------------
    always_comb begin
        result_d       = result_q;
        result_valid_d = 1'b0;
        // Only the owner's slice ever reaches the register.
        if (w_capture) begin
            result_d       = w_owner_data;
            result_valid_d = 1'b1;
        end
    end

    assign gnt          = gnt_q;
    assign gnt_id       = gnt_id_q;
    assign result       = result_q;
    assign result_valid = result_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_sync_reg_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_sync_reg_arbiter
// Description : Directed self-checking bench for sync_reg_arbiter (N=4, W=8,
//               MAX_HOLD=4). Each scenario task drives stimulus and compares
//               outputs against hand-computed values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sync_reg_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    logic           clk;
    logic           reset;
    logic [N-1:0]   req;
    logic [N*W-1:0] data;
    logic [N-1:0]   gnt;
    logic [1:0]     gnt_id;
    logic [W-1:0]   result;
    logic           result_valid;

    int pass_cnt;
    int total_cnt;

    logic [W-1:0] sl [N];

    sync_reg_arbiter #(.N(N), .W(W), .MAX_HOLD(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .data         (data),
        .gnt          (gnt),
        .gnt_id       (gnt_id),
        .result       (result),
        .result_valid (result_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One rising edge, then settle before sampling / driving.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req   = 4'b1111;
        for (int e = 0; e < 2; e++) begin
            tick();
            total_cnt++;
            if (gnt !== 4'b0000) $display("FAIL reset_gnt edge%0d: got %b expected 0000", e, gnt);
            else pass_cnt++;
            total_cnt++;
            if (gnt_id !== 2'd0) $display("FAIL reset_gnt_id edge%0d: got %0d expected 0", e, gnt_id);
            else pass_cnt++;
            total_cnt++;
            if (result !== 8'h00) $display("FAIL reset_result edge%0d: got %h expected 00", e, result);
            else pass_cnt++;
            total_cnt++;
            if (result_valid !== 1'b0) $display("FAIL reset_valid edge%0d: got %b expected 0", e, result_valid);
            else pass_cnt++;
        end
        reset = 1'b0;
        req   = 4'b0000;
    endtask

    task automatic test_single();
        do_reset();
        req = 4'b0001;
        tick();
        total_cnt++;
        if (gnt !== 4'b0001 || result_valid !== 1'b0)
            $display("FAIL single_grant: got gnt=%b valid=%b expected gnt=0001 valid=0", gnt, result_valid);
        else pass_cnt++;
        for (int c = 0; c < 3; c++) begin
            tick();
            total_cnt++;
            if (result !== 8'hA5 || result_valid !== 1'b1 || gnt !== 4'b0001)
                $display("FAIL single_capture%0d: got result=%h valid=%b gnt=%b expected A5 1 0001",
                         c, result, result_valid, gnt);
            else pass_cnt++;
        end
        req = 4'b0000;
        tick();
        total_cnt++;
        if (gnt !== 4'b0000 || gnt_id !== 2'd0 || result_valid !== 1'b0 || result !== 8'hA5)
            $display("FAIL single_release: got gnt=%b id=%0d valid=%b result=%h expected 0000 0 0 A5",
                     gnt, gnt_id, result_valid, result);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (gnt !== 4'b0000 || result_valid !== 1'b0 || result !== 8'hA5)
            $display("FAIL single_idle_hold: got gnt=%b valid=%b result=%h expected 0000 0 A5",
                     gnt, result_valid, result);
        else pass_cnt++;
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_gnt;
        int owner;
        int nxt;
        do_reset();
        req = 4'b1111;
        tick();
        total_cnt++;
        if (gnt !== 4'b0001 || gnt_id !== 2'd0)
            $display("FAIL rr_first_grant: got gnt=%b id=%0d expected 0001 0", gnt, gnt_id);
        else pass_cnt++;
        for (int t = 0; t < 5; t++) begin
            owner = t % 4;
            nxt   = (owner + 1) % 4;
            for (int c = 0; c < 4; c++) begin
                tick();
                exp_gnt = (c == 3) ? (4'b0001 << nxt) : (4'b0001 << owner);
                total_cnt++;
                if (result !== sl[owner] || result_valid !== 1'b1 || gnt !== exp_gnt)
                    $display("FAIL rr_owner%0d_cap%0d: got result=%h valid=%b gnt=%b expected %h 1 %b",
                             owner, c, result, result_valid, gnt, sl[owner], exp_gnt);
                else pass_cnt++;
            end
        end
        req = 4'b0000;
    endtask

    task automatic test_skip_idle();
        do_reset();
        req = 4'b0010;
        tick();
        total_cnt++;
        if (gnt !== 4'b0010 || gnt_id !== 2'd1)
            $display("FAIL skip_grant1: got gnt=%b id=%0d expected 0010 1", gnt, gnt_id);
        else pass_cnt++;
        tick();
        tick();
        tick();
        total_cnt++;
        if (result !== 8'h3C || result_valid !== 1'b1 || gnt !== 4'b0010)
            $display("FAIL skip_cap3: got result=%h valid=%b gnt=%b expected 3C 1 0010", result, result_valid, gnt);
        else pass_cnt++;
        req = 4'b1011;
        tick();
        total_cnt++;
        if (gnt !== 4'b1000 || gnt_id !== 2'd3 || result !== 8'h3C || result_valid !== 1'b1)
            $display("FAIL skip_handoff: got gnt=%b id=%0d result=%h valid=%b expected 1000 3 3C 1",
                     gnt, gnt_id, result, result_valid);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (result !== 8'hC3 || result_valid !== 1'b1)
            $display("FAIL skip_new_owner_cap: got result=%h valid=%b expected C3 1", result, result_valid);
        else pass_cnt++;
        req = 4'b0000;
    endtask

    task automatic test_back_to_back();
        do_reset();
        req = 4'b0100;
        tick();
        total_cnt++;
        if (gnt !== 4'b0100 || gnt_id !== 2'd2)
            $display("FAIL b2b_grant2: got gnt=%b id=%0d expected 0100 2", gnt, gnt_id);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (result !== 8'h5A || result_valid !== 1'b1)
            $display("FAIL b2b_cap2: got result=%h valid=%b expected 5A 1", result, result_valid);
        else pass_cnt++;
        req = 4'b0001;
        tick();
        total_cnt++;
        if (gnt !== 4'b0001 || gnt_id !== 2'd0 || result !== 8'h5A || result_valid !== 1'b0)
            $display("FAIL b2b_handoff: got gnt=%b id=%0d result=%h valid=%b expected 0001 0 5A 0",
                     gnt, gnt_id, result, result_valid);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (result !== 8'hA5 || result_valid !== 1'b1)
            $display("FAIL b2b_cap0: got result=%h valid=%b expected A5 1", result, result_valid);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        // Start ownership at requester 2 so that a stale pointer would show.
        do_reset();
        req = 4'b0100;
        tick();
        req = 4'b1111;
        tick();
        total_cnt++;
        if (gnt !== 4'b0100 || result !== 8'h5A || result_valid !== 1'b1)
            $display("FAIL mid_pre: got gnt=%b result=%h valid=%b expected 0100 5A 1", gnt, result, result_valid);
        else pass_cnt++;
        reset = 1'b1;
        tick();
        total_cnt++;
        if (gnt !== 4'b0000 || gnt_id !== 2'd0 || result !== 8'h00 || result_valid !== 1'b0)
            $display("FAIL mid_reset: got gnt=%b id=%0d result=%h valid=%b expected 0000 0 00 0",
                     gnt, gnt_id, result, result_valid);
        else pass_cnt++;
        reset = 1'b0;
        tick();
        total_cnt++;
        if (gnt !== 4'b0001 || gnt_id !== 2'd0 || result_valid !== 1'b0)
            $display("FAIL mid_regrant: got gnt=%b id=%0d valid=%b expected 0001 0 0", gnt, gnt_id, result_valid);
        else pass_cnt++;
        req = 4'b0000;
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        sl[0] = 8'hA5;
        sl[1] = 8'h3C;
        sl[2] = 8'h5A;
        sl[3] = 8'hC3;
        data  = {8'hC3, 8'h5A, 8'h3C, 8'hA5};
        reset = 1'b1;
        req   = 4'b0000;
        #2;
        test_reset();
        test_single();
        test_round_robin();
        test_skip_idle();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sync_reg_arbiter.md
SYNC_REG_ARBITER -- requirements
Module: sync_reg_arbiter

Interface
REQ-001 The block SHALL have parameter N, default 4, giving the number of requesters (2..8).
REQ-002 The block SHALL have parameter W, default 8, giving the data width per requester.
REQ-003 The block SHALL have parameter MAX_HOLD, default 4, giving the maximum consecutive owned cycles per grant (>=1).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset, sampled on the rising edge of clk.
REQ-006 The block SHALL have port req, input, N bits: req[i] high means requester i wants the shared register.
REQ-007 The block SHALL have port data, input, N*W bits: slice [i*W +: W] is requester i's write data.
REQ-008 The block SHALL have port gnt, output, N bits: registered, one-hot or zero, current owner.
REQ-009 The block SHALL have port gnt_id, output, clog2(N) bits: registered index of the current owner, 0 when idle.
REQ-010 The block SHALL have port result, output, W bits: the shared synchronous register contents.
REQ-011 The block SHALL have port result_valid, output, 1 bit: high for exactly the cycle after each capture.

Function
REQ-012 The block SHALL implement two states: IDLE (gnt=0) and OWNED (exactly one gnt bit high).
REQ-013 The block SHALL hold a round-robin pointer ptr (clog2(N) bits); owner search order is ptr, ptr+1, ..., wrapping mod N.
REQ-014 In IDLE, the first edge with |req=1 SHALL make the block select the first set req bit in search order, set gnt/gnt_id, clear hold_cnt, and enter OWNED; no capture occurs on that edge.
REQ-015 In OWNED with owner k, each edge with req[k]=1 SHALL make the block load data slice k into result, drive result_valid=1 the next cycle, and increment hold_cnt.
REQ-016 In OWNED, each edge with req[k]=0 SHALL leave result unchanged, drive result_valid=0, and perform a release.
REQ-017 In OWNED, a capture edge with hold_cnt==MAX_HOLD-1 SHALL still capture, then perform a release; each grant thus yields at most MAX_HOLD captures.
REQ-018 On a release, the block SHALL set ptr to (k+1) mod N, then search req sampled on that same edge starting at (k+1) mod N.
REQ-019 On a release where the search hits, the block SHALL load the new gnt/gnt_id, clear hold_cnt, and stay OWNED, with no idle bubble; k itself may be re-granted only if no other req is set.
REQ-020 On a release where the search misses, the block SHALL clear gnt and gnt_id and enter IDLE.
REQ-021 On any edge with no capture, result SHALL hold its value and result_valid SHALL be 0.
REQ-022 Requests from non-owners SHALL never affect result while OWNED.
REQ-023 The latency from req rise in IDLE to gnt SHALL be 1 edge, and to first result_valid 2 edges.

Reset
REQ-024 When reset=1 at an edge, the block SHALL clear gnt, gnt_id, result, result_valid, hold_cnt and ptr to 0 and set state to IDLE; reset overrides all other activity, including mid-ownership.
REQ-025 The first edge after reset deasserts SHALL be evaluated as IDLE with ptr=0.

Verification
REQ-026 reset=1 for 2 edges with req=1111 -> gnt=0000, gnt_id=0, result=00, result_valid=0 throughout.
REQ-027 req=0001 for 4 cycles (sampled at edges 1-4), slice0=A5 -> gnt=0001 after edge 1; result=A5 with result_valid=1 after edges 2, 3, 4; gnt=0000 and IDLE after edge 5.
REQ-028 req=1111 held continuously -> owners 0,1,2,3,0 in turn, each with exactly 4 captures of its own slice, and gnt never 0000 between owners.
REQ-029 Owner 1 releases with req=1011 on that edge -> gnt=1000 and gnt_id=3 on the next cycle (ptr=2 skips idle requester 2).
REQ-030 Owner 2 drops req on the same edge requester 0 raises -> gnt=0001 after that edge with no idle cycle; result unchanged on that edge.
REQ-031 reset=1 during OWNED with captures in flight -> all outputs are 0 after that edge, and the next grant with req=1111 goes to requester 0.
